// File: rtl/zion_bc_skid_dff_pkg.sv
// zion_bc_pkg: shared flow-control types for the basic circuit library
package zion_bc_pkg;
    typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e;
endpackage

// File: rtl/zion_bc_skid_dff_if.sv
// zion_bc_skid_dff_if: valid/ready stream through the skid buffer, upstream and downstream sides
interface zion_bc_skid_dff_if #(parameter int WIDTH = 32);
    logic             i_vld;
    logic             i_rdy;
    logic [WIDTH-1:0] i_dat;
    logic             o_vld;
    logic             o_rdy;
    logic [WIDTH-1:0] o_dat;
    logic [1:0]       o_cnt;
    modport master (output i_vld, i_dat, o_rdy, input i_rdy, o_vld, o_dat, o_cnt);
    modport slave  (input i_vld, i_dat, o_rdy, output i_rdy, o_vld, o_dat, o_cnt);
endinterface

// File: rtl/zion_bc_skid_dff_en_dff.sv
// zion_bc_en_dff: enabled register with synchronous active-high reset to INI_DATA
module zion_bc_en_dff #(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    always_ff @(posedge clk)
        if (rst) q <= INI_DATA;
        else if (en) q <= d;
endmodule

// File: rtl/zion_bc_skid_dff.sv
// zion_bc_skid_dff: two-entry skid buffer, registered valid/ready stream with no o_rdy->i_rdy path
module zion_bc_skid_dff
    import zion_bc_pkg::*;
#(
    parameter int             WIDTH    = 32,
    parameter logic [WIDTH-1:0] INI_DATA = '0
) (
    input logic                  clk,
    input logic                  rst,
    input logic                  flush,
    zion_bc_skid_dff_if.slave    s
);
    skid_state_e      r_state, w_nxt;
    logic             w_in_fire, w_out_fire;
    logic             w_main_en, w_skid_en;
    logic [WIDTH-1:0] w_main_d, w_skid_d, w_main_q, w_skid_q;

    assign s.i_rdy    = ~rst & ~flush & (r_state != TWO);
    assign s.o_vld    = r_state != EMPTY;
    assign s.o_cnt    = r_state;
    assign s.o_dat    = w_main_q;
    assign w_in_fire  = s.i_vld & s.i_rdy;
    assign w_out_fire = s.o_vld & s.o_rdy;

    always_comb begin
        w_nxt = flush ? EMPTY :
                r_state == EMPTY ? (w_in_fire ? ONE : EMPTY) :
                r_state == ONE   ? ((w_in_fire & ~w_out_fire) ? TWO :
                                    (~w_in_fire & w_out_fire) ? EMPTY : ONE) :
                                   (w_out_fire ? ONE : TWO);
    end

    always_ff @(posedge clk)
        if (rst) r_state <= EMPTY;
        else r_state <= w_nxt;

    // flush reloads both registers with INI_DATA through the normal enable path
    assign w_main_en = flush | (r_state == EMPTY & w_in_fire) | (r_state == ONE & w_in_fire & w_out_fire)
                     | (r_state == TWO & w_out_fire);
    assign w_main_d  = flush ? INI_DATA : (r_state == TWO ? w_skid_q : s.i_dat);
    assign w_skid_en = flush | (r_state == ONE & w_in_fire & ~w_out_fire);
    assign w_skid_d  = flush ? INI_DATA : s.i_dat;

    zion_bc_en_dff #(.WIDTH(WIDTH), .INI_DATA(INI_DATA)) u_main (
        .clk(clk), .rst(rst), .en(w_main_en), .d(w_main_d), .q(w_main_q)
    );
    zion_bc_en_dff #(.WIDTH(WIDTH), .INI_DATA(INI_DATA)) u_skid (
        .clk(clk), .rst(rst), .en(w_skid_en), .d(w_skid_d), .q(w_skid_q)
    );
endmodule

// File: tb/tb_zion_bc_skid_dff.sv
// tb_zion_bc_skid_dff: random and directed stream checked against a queue model of the buffer
module tb_zion_bc_skid_dff;
    logic clk = 0, rst = 1, flush = 0, chk_en = 0;
    int checks = 0, errors = 0;
    logic [31:0] exp_q[$];
    zion_bc_skid_dff_if #(.WIDTH(32)) bus();
    zion_bc_skid_dff #(.WIDTH(32), .INI_DATA(32'h1)) dut (.clk(clk), .rst(rst), .flush(flush), .s(bus));

    always #5 clk = ~clk;

    function automatic void chk(string n, logic [63:0] a, logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", n, a, e);
        end
    endfunction

    // one cycle of stimulus; the model's occupancy is the number of words queued and not yet emitted
    task automatic cyc(input logic v, input logic [31:0] d, input logic ordy, input logic f, input logic r, output bit acc);
        @(negedge clk);
        rst = r; flush = f; bus.i_vld = v; bus.i_dat = d; bus.o_rdy = ordy;
        #1;
        if (chk_en) begin
            chk("cnt", bus.o_cnt, exp_q.size());
            chk("vld", bus.o_vld, exp_q.size() != 0);
            chk("rdy", bus.i_rdy, !r && !f && exp_q.size() < 2);
        end
        acc = v && bus.i_rdy;
        if (acc) exp_q.push_back(d);
        if (r) chk_en = 1;
    endtask

    task automatic send(input logic [31:0] d, input logic ordy);
        bit acc = 0;
        for (int k = 0; k < 20 && !acc; k++) cyc(1, d, ordy || k > 3, 0, 0, acc);
        if (!acc) chk("send_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) cyc(0, 0, 1, 0, 0, acc);
    endtask

    // monitor: every downstream transfer must match the oldest outstanding word
    initial forever begin
        @(negedge clk);
        #2;
        if (bus.o_vld === 1'b1 && bus.o_rdy === 1'b1) begin
            if (exp_q.size() == 0) chk("unexpected_out", bus.o_dat, 0);
            else chk("dat", bus.o_dat, exp_q.pop_front());
        end
        if (rst || flush) exp_q.delete();
    end

    initial begin
        bit acc;
        logic [31:0] pend;
        bus.i_vld = 0; bus.i_dat = 0; bus.o_rdy = 0;
        cyc(1, 32'hA5A5_A5A5, 0, 0, 1, acc);
        cyc(1, 32'hA5A5_A5A5, 0, 0, 1, acc);
        chk("rst_dat", bus.o_dat, 32'h1);
        idle(3);
        for (int i = 0; i < 100; i++) begin
            cyc(1, i, 1, 0, 0, acc);
            chk("stream_acc", acc, 1);
        end
        idle(3);
        cyc(1, 10, 1, 0, 0, acc);
        cyc(1, 11, 0, 0, 0, acc);
        cyc(1, 12, 0, 0, 0, acc);
        chk("bp_hold", acc, 0);
        cyc(1, 12, 0, 0, 0, acc);
        send(12, 1);
        idle(4);
        cyc(1, 20, 0, 0, 0, acc);
        cyc(1, 21, 0, 0, 0, acc);
        cyc(1, 22, 0, 1, 0, acc);
        chk("flush_acc", acc, 0);
        idle(1);
        chk("flush_dat", bus.o_dat, 32'h1);
        idle(2);
        cyc(1, 30, 0, 0, 0, acc);
        cyc(1, 31, 0, 0, 0, acc);
        cyc(0, 0, 0, 0, 1, acc);
        idle(1);
        send(7, 1);
        send(8, 1);
        idle(4);
        pend = $urandom;
        for (int i = 0; i < 10000; i++) begin
            cyc($urandom_range(0, 9) < 7, pend, $urandom_range(0, 1), $urandom_range(0, 63) == 0,
                $urandom_range(0, 255) == 0, acc);
            if (acc) pend = $urandom;
        end
        idle(5);
        chk("drain", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/zion_bc_skid_dff.md
# zion_bc_skid_dff

Flow-controlled pipeline register for the basic circuit library: a two-entry skid buffer that registers a valid/ready stream while keeping every output of the block (o_vld, o_dat, i_rdy) free of combinational paths from its downstream inputs, apart from the documented rst/flush gating of i_rdy. It is the handshake-aware counterpart of the library's plain reset-value DFF. It is placed between a producer and a consumer to break the ready timing path, with no loss, duplication or reordering of data.

## Interface
- WIDTH, 32, data width in bits (>=1)
- INI_DATA, '0, reset/flush value of both data registers (WIDTH bits)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- flush  in  1  synchronous drop of buffered contents, active-high
- i_vld  in  1  upstream data valid
- i_rdy  out  1  upstream ready
- i_dat  in  WIDTH  upstream data
- o_vld  out  1  downstream data valid
- o_rdy  in  1  downstream ready
- o_dat  out  WIDTH  downstream data
- o_cnt  out  2  occupancy, 0..2

## Operation
- Storage: main register (drives o_dat) and skid register. State: EMPTY (cnt 0), ONE (main full), TWO (main and skid full).
- Handshakes: in_fire = i_vld & i_rdy; out_fire = o_vld & o_rdy. Upstream must hold i_vld/i_dat until fire; the block holds o_vld/o_dat until out_fire.
- o_vld = (state != EMPTY); o_cnt = 0/1/2 per state; i_rdy = ~rst & ~flush & (state != TWO).
- EMPTY: in_fire -> main<=i_dat, go ONE.
- ONE, in_fire & out_fire -> main<=i_dat, stay ONE.
- ONE, in_fire only -> skid<=i_dat, go TWO.
- ONE, out_fire only -> go EMPTY.
- TWO: i_rdy=0; out_fire -> main<=skid, go ONE; otherwise hold.
- flush (rst=0): next state EMPTY, main and skid <= INI_DATA, no input accepted that cycle. An out_fire in the same cycle still counts as a completed transfer of the current o_dat.
- rst: state EMPTY, main/skid <= INI_DATA. Priority is rst > flush > normal operation.
- o_dat holds its last value while o_vld=0 and is don't-care to consumers.
- FIFO order is strict: skid data always leaves after the main data.

## Timing
- Reset values, visible from the first edge with rst=1: o_vld=0, o_cnt=0, o_dat=INI_DATA, and i_rdy=0 while rst is high. i_rdy=1 in the first cycle after rst drops.
- Latency: 1 cycle. Data accepted at edge N is on o_dat with o_vld=1 after edge N.
- Throughput: 1 transfer/cycle sustained with o_rdy=1.
- i_rdy depends only on state flops plus rst/flush, never on o_rdy or i_vld.
- After one stall cycle (o_rdy=0), i_rdy drops for exactly as long as state is TWO.
- Reset or flush mid-stream discards both entries, with no partial output afterwards.

## Structure
- Package zion_bc_pkg: typedef enum logic [1:0] {EMPTY, ONE, TWO} skid_state_e. Shared with future flow-control blocks.
- Sub-module zion_bc_en_dff (WIDTH, INI_DATA; clk, rst, en, d, q): enabled DFF with synchronous active-high reset to INI_DATA. Instantiated twice, for main and skid.
- Top level: state register, next-state logic, and the main-register input mux (i_dat or skid).

## Test plan
- Reset: rst=1 for 2 cycles with i_vld=1 and i_dat=32'hA5A5_A5A5 -> o_vld=0, o_dat=INI_DATA=32'h1, i_rdy=0, no word emitted after rst drops.
- Streaming: o_rdy=1, send 0..99 back-to-back -> 0..99 out in order, 1-cycle latency, i_rdy stays 1, o_cnt<=1.
- Backpressure: send 10, 11, 12 with o_rdy=0 from the cycle after 10 is accepted -> o_cnt=2, i_rdy=0, 12 held at input. Release o_rdy -> outputs 10, 11, 12 with no loss or duplication.
- Flush with entries buffered: o_cnt=2, assert flush with i_vld=1 -> next cycle o_vld=0, o_cnt=0, o_dat=INI_DATA, and the input word is not consumed.
- Random: random i_vld/o_rdy/i_dat for 10k cycles against a scoreboard queue -> exact order match, o_cnt in range, i_rdy=0 only in TWO/rst/flush.
- Reset in state TWO: o_rdy=0 and o_cnt=2, pulse rst -> EMPTY next cycle, o_vld=0, subsequent stream 7, 8 emerges as 7, 8 only.
